// File: rtl/de10_pkg.sv
// -----------------------------------------------------------------------------
// de10_pkg
// Board-level constants shared by the DE10-Lite lab modules.
//   CLK50_HZ            frequency of MAX10_CLK1_50 in Hz
//   SW_WIDTH            number of slide switches on the board
//   DEFAULT_DEBOUNCE_MS default switch debounce stable time in ms
//   debounce_cycles()   clock cycles a level must hold to be accepted
// -----------------------------------------------------------------------------
package de10_pkg;

   localparam int CLK50_HZ            = 50_000_000;
   localparam int SW_WIDTH            = 10;
   localparam int DEFAULT_DEBOUNCE_MS = 10;

   // Division first keeps the intermediate product small for large clocks.
   function automatic int debounce_cycles(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage : de10_pkg

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_bit
// One switch channel: two-flop synchroniser, stability counter, clean flop
// and (optionally) registered change pulses.
// Optional feature macro: SW_DEBOUNCE_EDGE_EN (builds the rise/fall pulse
// registers; when undefined sw_rise/sw_fall are tied to 0).
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   sw_raw    raw switch level, asynchronous to clk
//   sw_clean  debounced level
//   sw_rise   one-cycle pulse in the first cycle sw_clean reads 1
//   sw_fall   one-cycle pulse in the first cycle sw_clean reads 0
// -----------------------------------------------------------------------------
module sw_debounce_bit #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_clean,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int                CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_reg;
   logic             s2_reg;
   logic             clean_reg;
   logic             clean_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             update;

   // Any return to match clears the count, so only an unbroken run of
   // STABLE_CYCLES mismatching s2 samples can move the clean level.
   always_comb begin
      cnt_next   = cnt_reg;
      clean_next = clean_reg;
      update     = 1'b0;
      if (s2_reg == clean_reg) begin
         cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
         update     = 1'b1;
         clean_next = s2_reg;
         cnt_next   = '0;
      end else begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg    <= 1'b0;
         s2_reg    <= 1'b0;
         cnt_reg   <= '0;
         clean_reg <= 1'b0;
      end else begin
         s1_reg    <= sw_raw;
         s2_reg    <= s1_reg;
         cnt_reg   <= cnt_next;
         clean_reg <= clean_next;
      end
   end

   assign sw_clean = clean_reg;

`ifdef SW_DEBOUNCE_EDGE_EN
   logic rise_reg;
   logic fall_reg;

   // Loaded on the same edge as clean_reg so the pulse lines up with the
   // first cycle of the new clean level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         rise_reg <= update &  s2_reg;
         fall_reg <= update & ~s2_reg;
      end
   end

   assign sw_rise = rise_reg;
   assign sw_fall = fall_reg;
`else
   assign sw_rise = 1'b0;
   assign sw_fall = 1'b0;
`endif

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Synchronises and debounces the DE10-Lite slide switches into the
// MAX10_CLK1_50 domain; optional one-cycle change pulses.
// Optional feature macro: SW_DEBOUNCE_EDGE_EN (enables SW_RISE/SW_FALL;
// otherwise they are constant 0, ports always present).
// Parameters: WIDTH, CLK_HZ, DEBOUNCE_MS; STABLE_CYCLES = CLK_HZ/1000*DEBOUNCE_MS.
// Ports:
//   MAX10_CLK1_50  system clock
//   RESET_N        asynchronous active-low reset
//   SW_RAW         raw switch pins (asynchronous)
//   SW_CLEAN       debounced switch vector
//   SW_RISE        per-bit one-cycle pulse on SW_CLEAN 0->1
//   SW_FALL        per-bit one-cycle pulse on SW_CLEAN 1->0
// -----------------------------------------------------------------------------
module sw_debounce
   import de10_pkg::*;
#(
   parameter int WIDTH       = SW_WIDTH,
   parameter int CLK_HZ      = CLK50_HZ,
   parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS
) (
   input  logic             MAX10_CLK1_50,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] SW_RAW,
   output logic [WIDTH-1:0] SW_CLEAN,
   output logic [WIDTH-1:0] SW_RISE,
   output logic [WIDTH-1:0] SW_FALL
);

   localparam int STABLE_CYCLES = debounce_cycles(CLK_HZ, DEBOUNCE_MS);

   // A one-cycle window would make the debouncer a plain synchroniser and
   // collapse the counter to zero bits.
   generate
      if (STABLE_CYCLES < 2) begin : g_bad_cfg
         $error("sw_debounce: STABLE_CYCLES must be >= 2");
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         sw_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
         ) u_bit (
            .clk      (MAX10_CLK1_50),
            .rst_n    (RESET_N),
            .sw_raw   (SW_RAW[gi]),
            .sw_clean (SW_CLEAN[gi]),
            .sw_rise  (SW_RISE[gi]),
            .sw_fall  (SW_FALL[gi])
         );
      end
   endgenerate

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Directed and randomised stimulus for sw_debounce with a sliding-window
// reference model and a queue-based scoreboard. Expected pulse values follow
// SW_DEBOUNCE_EDGE_EN (constant 0 when undefined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sw_debounce;

   localparam int W  = 10;
   localparam int SC = 4;   // 1000/1000*4

   typedef struct packed {
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } exp_t;

   logic         clk = 1'b0;
   logic         RESET_N = 1'b0;
   logic [W-1:0] SW_RAW = '0;
   logic [W-1:0] SW_CLEAN;
   logic [W-1:0] SW_RISE;
   logic [W-1:0] SW_FALL;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t         exp_q [$];
   logic [W-1:0] hist  [$];   // raw value sampled at each of the last SC+2 edges
   logic [W-1:0] m_clean;

   sw_debounce #(
      .WIDTH       (W),
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4)
   ) dut (
      .MAX10_CLK1_50 (clk),
      .RESET_N       (RESET_N),
      .SW_RAW        (SW_RAW),
      .SW_CLEAN      (SW_CLEAN),
      .SW_RISE       (SW_RISE),
      .SW_FALL       (SW_FALL)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_checks++;
      if (act !== expv)
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      else
         n_pass++;
   endtask

   // Reference model: the clean level of a bit flips at edge n exactly when
   // the raw samples taken at edges n-SC-1 .. n-2 all disagree with it.
   initial begin
      exp_t         e;
      logic [W-1:0] nxt;
      bit           all_diff;
      m_clean = '0;
      for (int i = 0; i < SC + 2; i++) hist.push_back('0);
      forever begin
         @(posedge clk);
         if (!RESET_N) begin
            hist.delete();
            for (int i = 0; i < SC + 2; i++) hist.push_back('0);
            m_clean = '0;
            e = '0;
         end else begin
            hist.push_back(SW_RAW);
            void'(hist.pop_front());
            nxt = m_clean;
            for (int b = 0; b < W; b++) begin
               all_diff = 1'b1;
               for (int k = 2; k <= SC + 1; k++)
                  if (hist[SC + 1 - k][b] == m_clean[b]) all_diff = 1'b0;
               if (all_diff) nxt[b] = ~m_clean[b];
            end
            e.clean = nxt;
`ifdef SW_DEBOUNCE_EDGE_EN
            e.rise = nxt & ~m_clean;
            e.fall = ~nxt & m_clean;
`else
            e.rise = '0;
            e.fall = '0;
`endif
            m_clean = nxt;
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: one output beat per clock, checked away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            $display("beat t=%0t raw=%h clean=%h rise=%h fall=%h", $time, SW_RAW, SW_CLEAN, SW_RISE, SW_FALL);
            chk("sw_clean", SW_CLEAN, e.clean);
            chk("sw_rise",  SW_RISE,  e.rise);
            chk("sw_fall",  SW_FALL,  e.fall);
         end
      end
   end

   // Hold v on SW_RAW for n clock edges.
   task automatic apply(input logic [W-1:0] v, input int n);
      @(negedge clk);
      #1;
      SW_RAW = v;
      repeat (n) @(posedge clk);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once.
   task automatic reset_pulse();
      @(negedge clk);
      #1;
      RESET_N = 1'b0;
      #1;
      chk("rst_clean", SW_CLEAN, '0);
      chk("rst_rise",  SW_RISE,  '0);
      chk("rst_fall",  SW_FALL,  '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      RESET_N = 1'b1;
   endtask

   initial begin
      logic [W-1:0] cur;
      // Switches held high through reset.
      RESET_N = 1'b0;
      SW_RAW  = 10'h3FF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      RESET_N = 1'b1;
      repeat (9) @(posedge clk);

      // Simultaneous fall of every bit.
      apply(10'h000, 9);
      // Clean step on bit 3.
      apply(10'h008, 9);
      // Glitch on bit 0: three cycles high.
      apply(10'h009, 3);
      apply(10'h008, 9);
      // Bounce train on bit 0, then hold high.
      apply(10'h009, 1);
      apply(10'h008, 1);
      apply(10'h009, 1);
      apply(10'h008, 1);
      apply(10'h009, 9);
      // Rise all, fall all.
      apply(10'h3FF, 9);
      apply(10'h000, 9);
      // Rise all, then fall interrupted by reset mid-count.
      apply(10'h3FF, 9);
      apply(10'h000, 2);
      reset_pulse();
      repeat (9) @(posedge clk);

      // Random toggling with occasional resets.
      cur = '0;
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
         apply(cur, 1);
         if ($urandom_range(0, 99) == 0) reset_pulse();
      end
      apply(cur, 9);

      @(negedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sw_debounce
